// File: rtl/dict_search_ctrl.sv
// Forth dictionary controller: appends names on DEFINE and searches newest-to-oldest
// on FIND with one time-multiplexed key comparator, so the latest definition shadows older ones.
module dict_search_ctrl #(
  parameter int ENTRIES    = 8,
  parameter int KEY_WIDTH  = 8,
  parameter int KEY_LENGTH = 4
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic                                i_op,
  input  logic [KEY_WIDTH*KEY_LENGTH-1:0]     i_key,
  output logic                                o_done,
  output logic                                o_found,
  output logic [$clog2(ENTRIES)-1:0]          o_index,
  output logic [$clog2(ENTRIES):0]            o_count,
  output logic                                o_full
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int KW         = KEY_WIDTH * KEY_LENGTH;
  localparam logic [INDEX_BITS:0] FULL_COUNT = ENTRIES[INDEX_BITS:0];
  localparam logic [INDEX_BITS:0] LAST_COUNT = FULL_COUNT - {{INDEX_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

  state_t                  r_state;
  logic [KW-1:0]           r_entry [ENTRIES];
  logic [KW-1:0]           r_key;
  logic                    r_op;
  logic [INDEX_BITS-1:0]   r_ptr;
  logic [INDEX_BITS:0]     r_count;
  logic                    r_full;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_found;
  logic [INDEX_BITS-1:0]   r_index;
  logic                    w_match;
  logic                    w_room;

  assign w_room = (r_count < FULL_COUNT);

  // Character-wise equality of the slot under the pointer against the latched key.
  always_comb begin
    w_match = 1'b1;
    for (int c = 0; c < KEY_LENGTH; c++) begin
      w_match = w_match &
                (r_entry[r_ptr][c*KEY_WIDTH +: KEY_WIDTH] == r_key[c*KEY_WIDTH +: KEY_WIDTH]);
    end
  end

  // Name storage: deliberately not reset, slots at or above the count are never compared.
  always_ff @(posedge i_clk) begin
    if (!i_reset && (r_state == S_WRITE) && w_room) begin
      r_entry[r_count[INDEX_BITS-1:0]] <= r_key;
    end
  end

  // Command FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_key   <= {KW{1'b0}};
      r_op    <= 1'b0;
      r_ptr   <= {INDEX_BITS{1'b0}};
      r_count <= {(INDEX_BITS+1){1'b0}};
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_index <= {INDEX_BITS{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid && r_ready) begin
            r_key   <= i_key;
            r_op    <= i_op;
            r_ready <= 1'b0;
            if (i_op) begin
              r_state <= S_WRITE;
            end else if (r_count != {(INDEX_BITS+1){1'b0}}) begin
              r_ptr   <= INDEX_BITS'(r_count - {{INDEX_BITS{1'b0}}, 1'b1});
              r_state <= S_SCAN;
            end else begin
              r_found <= 1'b0;
              r_index <= {INDEX_BITS{1'b0}};
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_found <= 1'b1;
            r_index <= r_ptr;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_ptr == {INDEX_BITS{1'b0}}) begin
            r_found <= 1'b0;
            r_index <= {INDEX_BITS{1'b0}};
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr <= r_ptr - {{(INDEX_BITS-1){1'b0}}, 1'b1};
          end
        end
        S_WRITE: begin
          if (w_room) begin
            r_found <= 1'b1;
            r_index <= r_count[INDEX_BITS-1:0];
            r_count <= r_count + {{INDEX_BITS{1'b0}}, 1'b1};
            r_full  <= (r_count == LAST_COUNT);
          end else begin
            r_found <= 1'b0;
            r_index <= {INDEX_BITS{1'b0}};
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_found = r_found;
  assign o_index = r_index;
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

// File: tb/tb_dict_search_ctrl.sv
// Directed bench for dict_search_ctrl: handshake latency, shadowing, full dictionary, mid-command reset.
module tb_dict_search_ctrl;

  logic        clk;
  logic        rst;
  logic        t_valid;
  logic        t_op;
  logic [31:0] t_key;
  logic        o_ready;
  logic        o_done;
  logic        o_found;
  logic [2:0]  o_index;
  logic [3:0]  o_count;
  logic        o_full;

  int checks;
  int errors;

  dict_search_ctrl #(.ENTRIES(8), .KEY_WIDTH(8), .KEY_LENGTH(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (t_valid),
    .o_ready (o_ready),
    .i_op    (t_op),
    .i_key   (t_key),
    .o_done  (o_done),
    .o_found (o_found),
    .o_index (o_index),
    .o_count (o_count),
    .o_full  (o_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // String literals put the first character in the MSBs; the DUT wants it in the LSBs.
  function automatic logic [31:0] mk(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic op, input logic [31:0] name, input logic ef,
                     input int ei, input int elat, input int ecount, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    t_valid = 1'b1;
    t_op    = op;
    t_key   = mk(name);
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_op    = ~op;
    t_key   = ~t_key;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (o_done) break;
    end
    chk({tag, " latency"}, k, elat);
    chk({tag, " found"}, int'(o_found), int'(ef));
    chk({tag, " index"}, int'(o_index), ei);
    chk({tag, " count"}, int'(o_count), ecount);
    chk({tag, " ready_low_in_done"}, int'(o_ready), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  seen_done;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    t_valid   = 1'b0;
    t_op      = 1'b0;
    t_key     = 32'd0;
    seen_done = 0;

    do_reset();
    @(negedge clk);
    chk("rst ready", int'(o_ready), 1);
    chk("rst done",  int'(o_done),  0);
    chk("rst found", int'(o_found), 0);
    chk("rst index", int'(o_index), 0);
    chk("rst count", int'(o_count), 0);
    chk("rst full",  int'(o_full),  0);

    cmd(1'b0, "DUP ", 1'b0, 0, 1, 0, "find_empty");

    cmd(1'b1, "DUP ", 1'b1, 0, 2, 1, "def_dup");
    cmd(1'b1, "DROP", 1'b1, 1, 2, 2, "def_drop");
    cmd(1'b1, "SWAP", 1'b1, 2, 2, 3, "def_swap");

    cmd(1'b0, "DROP", 1'b1, 1, 3, 3, "find_drop");
    @(negedge clk);
    @(negedge clk);
    chk("hold found", int'(o_found), 1);
    chk("hold index", int'(o_index), 1);
    cmd(1'b0, "OVER", 1'b0, 0, 4, 3, "find_over_miss");

    cmd(1'b1, "DUP ", 1'b1, 3, 2, 4, "def_dup2");
    cmd(1'b0, "DUP ", 1'b1, 3, 2, 4, "find_dup_shadow");

    cmd(1'b1, "OVER", 1'b1, 4, 2, 5, "def_over");
    cmd(1'b1, "ROT ", 1'b1, 5, 2, 6, "def_rot");
    cmd(1'b1, "EMIT", 1'b1, 6, 2, 7, "def_emit");
    chk("not_full_at_7", int'(o_full), 0);
    cmd(1'b1, "KEY ", 1'b1, 7, 2, 8, "def_key");
    chk("full_at_8", int'(o_full), 1);
    cmd(1'b1, "NIP ", 1'b0, 0, 2, 8, "def_overflow");
    chk("full_after_overflow", int'(o_full), 1);

    cmd(1'b0, "DUP ", 1'b1, 3, 6, 8, "full_find_dup");
    cmd(1'b0, "DROP", 1'b1, 1, 8, 8, "full_find_drop");
    cmd(1'b0, "SWAP", 1'b1, 2, 7, 8, "full_find_swap");
    cmd(1'b0, "OVER", 1'b1, 4, 5, 8, "full_find_over");
    cmd(1'b0, "ROT ", 1'b1, 5, 4, 8, "full_find_rot");
    cmd(1'b0, "EMIT", 1'b1, 6, 3, 8, "full_find_emit");
    cmd(1'b0, "KEY ", 1'b1, 7, 2, 8, "full_find_key");
    cmd(1'b0, "NIP ", 1'b0, 0, 9, 8, "full_find_nip_miss");

    do_reset();
    cmd(1'b1, "AAAA", 1'b1, 0, 2, 1, "r_def_a");
    cmd(1'b1, "BBBB", 1'b1, 1, 2, 2, "r_def_b");
    cmd(1'b1, "CCCC", 1'b1, 2, 2, 3, "r_def_c");
    cmd(1'b1, "DDDD", 1'b1, 3, 2, 4, "r_def_d");
    cmd(1'b1, "EEEE", 1'b1, 4, 2, 5, "r_def_e");

    // Start a full-miss FIND (6 cycles) and reset it two cycles into the scan.
    @(negedge clk);
    t_valid = 1'b1;
    t_op    = 1'b0;
    t_key   = mk("ZZZZ");
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    @(negedge clk);
    if (o_done) seen_done++;
    @(negedge clk);
    if (o_done) seen_done++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready", int'(o_ready), 1);
    chk("abort count", int'(o_count), 0);
    chk("abort full",  int'(o_full),  0);
    for (int i = 0; i < 6; i++) begin
      if (o_done) seen_done++;
      @(negedge clk);
    end
    chk("abort no_done", seen_done, 0);
    cmd(1'b0, "AAAA", 1'b0, 0, 1, 0, "post_abort_find");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dict_search_ctrl.md
# dict_search_ctrl

Sequential controller for the Forth word dictionary. It owns ENTRIES name slots, each KEY_LENGTH characters of KEY_WIDTH bits. It serves two commands over a valid/ready handshake: DEFINE appends a name, and FIND searches newest-to-oldest, one slot per clock. It sits between the outer interpreter and the dictionary storage. It replaces the single-cycle parallel compare with a time-multiplexed comparator, and gives Forth shadowing semantics: the most recent definition wins.

## Interface
- ENTRIES, 8: number of dictionary slots; must be ≥ 2.
- KEY_WIDTH, 8: bits per name character.
- KEY_LENGTH, 4: characters per name.
- INDEX_BITS (localparam), $clog2(ENTRIES): slot index width.
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  command request.
- o_ready  out  1  high only in IDLE; a command is accepted on a cycle with i_valid && o_ready.
- i_op  in  1  0 = FIND, 1 = DEFINE; sampled at accept.
- i_key  in  KEY_WIDTH*KEY_LENGTH  name; character 0 sits in the LSBs; sampled at accept.
- o_done  out  1  one-cycle completion pulse.
- o_found  out  1  FIND: a match exists; DEFINE: the write succeeded. Valid with o_done, held until the next o_done.
- o_index  out  INDEX_BITS  FIND: the matching slot; DEFINE: the slot written. Valid with o_done, held; 0 when o_found = 0.
- o_count  out  INDEX_BITS+1  number of defined entries, 0..ENTRIES.
- o_full  out  1  o_count == ENTRIES.

## Operation
- Storage: register array entry[ENTRIES], each KEY_WIDTH*KEY_LENGTH bits. It is not cleared on reset; only slots below o_count are ever compared.
- A full key comparison is the equality of all KEY_LENGTH characters, performed in a single cycle.
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE
  - On accept, latch i_key and i_op.
  - FIND with o_count > 0: go to SCAN with ptr = o_count-1.
  - FIND with o_count == 0: go to DONE with found = 0.
  - DEFINE: go to WRITE.
- SCAN
  - Each cycle, compare entry[ptr] with the latched key.
  - Match: capture index = ptr, found = 1, go to DONE.
  - No match with ptr == 0: found = 0, index = 0, go to DONE.
  - Otherwise ptr decrements.
  - Search order is strictly descending, so the newest duplicate wins.
- WRITE
  - o_count < ENTRIES: entry[o_count] ← key, index = old o_count, found = 1, o_count increments.
  - o_count == ENTRIES: no write, found = 0, index = 0, o_count unchanged.
  - Either way, go to DONE.
- DONE: drive o_done = 1 for this cycle, with o_found and o_index updated in the same cycle, then go to IDLE.
- Duplicate DEFINE is legal: a new slot is always appended.
- i_key and i_op changes after accept have no effect on the command in flight.

## Timing
- Reset values: state IDLE, o_ready = 1, o_done = 0, o_found = 0, o_index = 0, o_count = 0, o_full = 0.
- i_reset asserted mid-command aborts it. No o_done is issued, and o_count returns to 0 on the next edge.
- Accept edge at cycle T.
  - DEFINE: o_done at T+2.
  - FIND, empty dictionary: o_done at T+1.
  - FIND: o_done at T+1+k, where k = number of slots compared (1..o_count). A hit in the newest slot gives T+2; a full miss gives T+1+o_count.
- o_ready is low from T+1 through the DONE cycle and returns high the cycle after o_done. This gives a minimum of 3 cycles between DEFINE accepts.
- o_full and o_count update in the DONE cycle of a successful DEFINE.
- A new command can be accepted the cycle after o_done. o_found and o_index remain stable until that command's o_done.

## Test plan
- Reset, then FIND "DUP " on the empty dictionary → o_done one cycle after accept, o_found = 0, o_index = 0, o_count = 0.
- DEFINE "DUP ", "DROP", "SWAP" → o_index = 0, 1, 2 in order, o_found = 1 each time, o_count = 3, each o_done two cycles after its accept.
- FIND "DROP" with 3 entries → o_found = 1, o_index = 1, o_done three cycles after accept. FIND "OVER" → o_found = 0, o_done four cycles after accept.
- DEFINE "DUP " a second time (slot 3), then FIND "DUP " → o_index = 3 (shadowing), o_done two cycles after accept.
- Fill all 8 slots → o_full = 1. A 9th DEFINE returns o_found = 0, o_count stays 8, and all stored slots are unchanged (verified by FIND on each name).
- Assert i_reset during SCAN of a 5-entry FIND → no o_done, o_count = 0, o_ready = 1 after the reset edge. The next FIND misses in one cycle.
